// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS controller.
// Holds the opcode/funct constants, the FSM state encoding, the datapath
// select encodings (EOp, ALUOp, RegDst, MemtoReg, NPCOp) and the one-hot
// instruction-class layout produced by mc_decode.
package mc_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // FSM states; the numeric values are visible on the debug state port
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_ALUWB  = 4'd3,
    S_MADDR  = 4'd4,
    S_MRD    = 4'd5,
    S_MWB    = 4'd6,
    S_MWR    = 4'd7,
    S_BR     = 4'd8,
    S_JMP    = 4'd9
  } state_t;

  // Extender modes
  localparam logic [1:0] EOP_SIGN     = 2'b00;
  localparam logic [1:0] EOP_ZERO     = 2'b01;
  localparam logic [1:0] EOP_UPPER    = 2'b10;
  localparam logic [1:0] EOP_SIGN_SH2 = 2'b11;

  // ALU operations
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_PASSB = 3'b011;

  // Register-file destination select
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // Register-file write-data select
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  // Next-PC select
  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JUMP = 2'b10;
  localparam logic [1:0] NPC_GPR  = 2'b11;

  // One-hot instruction class: bit positions
  localparam int CLS_N  = 10;
  localparam int C_ADDU = 0;
  localparam int C_SUBU = 1;
  localparam int C_ORI  = 2;
  localparam int C_LUI  = 3;
  localparam int C_LW   = 4;
  localparam int C_SW   = 5;
  localparam int C_BEQ  = 6;
  localparam int C_J    = 7;
  localparam int C_JAL  = 8;
  localparam int C_JR   = 9;

  typedef logic [CLS_N-1:0] cls_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller <-> datapath bundle.
//   opcode, funct, zero : instruction fields and ALU flag into the controller
//   PCWr..NPCOp         : write enables and datapath selects out of it
//   state, illegal      : debug state and unsupported-instruction flag
//   instr_cnt           : retired-instruction count (CNT_W bits)
// Modports: master = controller side, slave = datapath side.
interface mc_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             PCWr;
  logic             IRWr;
  logic             RegWr;
  logic             MemWr;
  logic [1:0]       EOp;
  logic             ALUSrc;
  logic [2:0]       ALUOp;
  logic [1:0]       RegDst;
  logic [1:0]       MemtoReg;
  logic [1:0]       NPCOp;
  logic [3:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  opcode, funct, zero,
    output PCWr, IRWr, RegWr, MemWr, EOp, ALUSrc, ALUOp,
           RegDst, MemtoReg, NPCOp, state, illegal, instr_cnt
  );

  modport slave (
    output opcode, funct, zero,
    input  PCWr, IRWr, RegWr, MemWr, EOp, ALUSrc, ALUOp,
           RegDst, MemtoReg, NPCOp, state, illegal, instr_cnt
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: purely combinational instruction classifier.
//   i_opcode  : IR[31:26]
//   i_funct   : IR[5:0], only meaningful for opcode 000000
//   o_cls     : one-hot instruction class (bit layout in mc_ctrl_pkg)
//   o_illegal : no supported instruction matched
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output cls_t       o_cls,
  output logic       o_illegal
);

  cls_t w_cls;

  always_comb begin
    w_cls = '0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADDU: w_cls[C_ADDU] = 1'b1;
          FN_SUBU: w_cls[C_SUBU] = 1'b1;
          FN_JR:   w_cls[C_JR]   = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  w_cls[C_ORI] = 1'b1;
      OP_LUI:  w_cls[C_LUI] = 1'b1;
      OP_LW:   w_cls[C_LW]  = 1'b1;
      OP_SW:   w_cls[C_SW]  = 1'b1;
      OP_BEQ:  w_cls[C_BEQ] = 1'b1;
      OP_J:    w_cls[C_J]   = 1'b1;
      OP_JAL:  w_cls[C_JAL] = 1'b1;
      default: ;
    endcase
  end

  assign o_cls     = w_cls;
  assign o_illegal = (w_cls == '0);

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control unit (Moore FSM).
//   clk   : clock, all state changes on its rising edge
//   reset : asynchronous active-high reset
//   bus   : mc_ctrl_if.master -- opcode/funct/zero in; write enables,
//           datapath selects, debug state, illegal and instr_cnt out
// Parameter CNT_W sets the instr_cnt width and must match the interface.
// Optional feature: define MC_CTRL_INSTR_CNT_EN to build the retired-
// instruction counter; otherwise instr_cnt is tied to zero.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  state_t r_state;
  state_t w_next;
  cls_t   r_cls;
  cls_t   w_dec_cls;
  cls_t   w_cls;
  logic   w_dec_illegal;

  logic       w_pcwr, w_irwr, w_regwr, w_memwr, w_alusrc, w_illegal;
  logic [1:0] w_eop, w_regdst, w_m2r, w_npc;
  logic [2:0] w_aluop;

  mc_decode u_decode (
    .i_opcode  (bus.opcode),
    .i_funct   (bus.funct),
    .o_cls     (w_dec_cls),
    .o_illegal (w_dec_illegal)
  );

  function automatic logic [1:0] eop_of(input cls_t c);
    if (c[C_ORI])      return EOP_ZERO;
    else if (c[C_LUI]) return EOP_UPPER;
    else if (c[C_BEQ]) return EOP_SIGN_SH2;
    else               return EOP_SIGN;
  endfunction

  function automatic logic [2:0] aluop_of(input cls_t c);
    if (c[C_SUBU])     return ALU_SUB;
    else if (c[C_ORI]) return ALU_OR;
    else if (c[C_LUI]) return ALU_PASSB;
    else               return ALU_ADD;
  endfunction

  // In DECODE the class comes straight from the IR; afterwards from the
  // copy latched when leaving DECODE, so EOp is stable across the whole
  // instruction even though it is first needed in DECODE.
  assign w_cls = (r_state == S_DECODE) ? w_dec_cls : r_cls;

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_dec_cls[C_ADDU] | w_dec_cls[C_SUBU] | w_dec_cls[C_ORI] | w_dec_cls[C_LUI])
          w_next = S_EXE;
        else if (w_dec_cls[C_LW] | w_dec_cls[C_SW])
          w_next = S_MADDR;
        else if (w_dec_cls[C_BEQ])
          w_next = S_BR;
        else if (w_dec_cls[C_J] | w_dec_cls[C_JAL] | w_dec_cls[C_JR])
          w_next = S_JMP;
        else
          w_next = S_FETCH;
      end
      S_EXE:    w_next = S_ALUWB;
      S_MADDR:  w_next = r_cls[C_LW] ? S_MRD : S_MWR;
      S_MRD:    w_next = S_MWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cls   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cls <= w_dec_cls;
    end
  end

  always_comb begin
    w_pcwr    = 1'b0;
    w_irwr    = 1'b0;
    w_regwr   = 1'b0;
    w_memwr   = 1'b0;
    w_alusrc  = 1'b0;
    w_illegal = 1'b0;
    w_eop     = EOP_SIGN;
    w_aluop   = ALU_ADD;
    w_regdst  = RD_RT;
    w_m2r     = M2R_ALU;
    w_npc     = NPC_PC4;
    if (r_state != S_FETCH) w_eop = eop_of(w_cls);
    case (r_state)
      S_FETCH: begin
        w_pcwr = 1'b1;
        w_irwr = 1'b1;
        w_npc  = NPC_PC4;
      end
      S_DECODE: w_illegal = w_dec_illegal;
      S_EXE, S_MADDR: begin
        w_alusrc = w_cls[C_ORI] | w_cls[C_LUI] | w_cls[C_LW] | w_cls[C_SW];
        w_aluop  = aluop_of(w_cls);
      end
      S_ALUWB: begin
        w_regwr  = 1'b1;
        w_regdst = (w_cls[C_ADDU] | w_cls[C_SUBU]) ? RD_RD : RD_RT;
        w_m2r    = M2R_ALU;
      end
      S_MWB: begin
        w_regwr  = 1'b1;
        w_regdst = RD_RT;
        w_m2r    = M2R_MEM;
      end
      S_MWR: w_memwr = 1'b1;
      S_BR: begin
        w_aluop = ALU_SUB;
        w_npc   = NPC_BR;
        w_pcwr  = bus.zero;
      end
      S_JMP: begin
        w_pcwr = 1'b1;
        w_npc  = w_cls[C_JR] ? NPC_GPR : NPC_JUMP;
        if (w_cls[C_JAL]) begin
          w_regwr  = 1'b1;
          w_regdst = RD_RA;
          w_m2r    = M2R_PC4;
        end
      end
      default: ;
    endcase
    // The state register already sits in FETCH during reset, but FETCH
    // itself drives PCWr/IRWr, so outputs are silenced explicitly.
    if (reset) begin
      w_pcwr    = 1'b0;
      w_irwr    = 1'b0;
      w_regwr   = 1'b0;
      w_memwr   = 1'b0;
      w_alusrc  = 1'b0;
      w_illegal = 1'b0;
      w_eop     = EOP_SIGN;
      w_aluop   = ALU_ADD;
      w_regdst  = RD_RT;
      w_m2r     = M2R_ALU;
      w_npc     = NPC_PC4;
    end
  end

  assign bus.PCWr     = w_pcwr;
  assign bus.IRWr     = w_irwr;
  assign bus.RegWr    = w_regwr;
  assign bus.MemWr    = w_memwr;
  assign bus.EOp      = w_eop;
  assign bus.ALUSrc   = w_alusrc;
  assign bus.ALUOp    = w_aluop;
  assign bus.RegDst   = w_regdst;
  assign bus.MemtoReg = w_m2r;
  assign bus.NPCOp    = w_npc;
  assign bus.state    = r_state;
  assign bus.illegal  = w_illegal;

`ifdef MC_CTRL_INSTR_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Every final state always returns to FETCH, so being in one is the
  // retire event; illegal instructions leave from DECODE and never count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state inside {S_ALUWB, S_MWB, S_MWR, S_BR, S_JMP}) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.instr_cnt = r_cnt;
`else
  assign bus.instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

  typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW,
                    K_BEQ, K_J, K_JAL, K_JR, K_ILL} kind_t;

  typedef struct packed {
    logic [3:0] st;
    logic       pcwr;
    logic       irwr;
    logic       regwr;
    logic       memwr;
    logic [1:0] eop;
    logic       alusrc;
    logic [2:0] aluop;
    logic [1:0] regdst;
    logic [1:0] m2r;
    logic [1:0] npc;
    logic       ill;
  } outs_t;

`ifdef MC_CTRL_INSTR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(32)) bus ();
  mc_ctrl_if #(.CNT_W(4))  bus4 ();

  mc_ctrl #(.CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(bus.master));
  mc_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4.master));

  int checks   = 0;
  int failures = 0;
  int unsigned model_cnt = 0;
  outs_t exp_q[$];

  function automatic outs_t observe();
    outs_t o;
    o.st     = bus.state;
    o.pcwr   = bus.PCWr;
    o.irwr   = bus.IRWr;
    o.regwr  = bus.RegWr;
    o.memwr  = bus.MemWr;
    o.eop    = bus.EOp;
    o.alusrc = bus.ALUSrc;
    o.aluop  = bus.ALUOp;
    o.regdst = bus.RegDst;
    o.m2r    = bus.MemtoReg;
    o.npc    = bus.NPCOp;
    o.ill    = bus.illegal;
    return o;
  endfunction

  function automatic logic [31:0] exp_cnt32();
    return CNT_ON ? 32'(model_cnt) : 32'd0;
  endfunction

  function automatic logic [3:0] exp_cnt4();
    logic [31:0] c;
    c = exp_cnt32();
    return c[3:0];
  endfunction

  task automatic check_cycle(input string tag, input int cyc, input outs_t e);
    outs_t o;
    o = observe();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s cyc=%0d outputs got=%h want=%h", tag, cyc, o, e);
    end
    checks++;
    assert (!(bus.RegWr && bus.MemWr)) else begin
      failures++;
      $error("FAIL %s cyc=%0d regwr_memwr_both got=1 want=0", tag, cyc);
    end
    checks++;
    assert (bus.instr_cnt === exp_cnt32()) else begin
      failures++;
      $error("FAIL %s cyc=%0d instr_cnt got=%0d want=%0d", tag, cyc, bus.instr_cnt, exp_cnt32());
    end
    checks++;
    assert (bus4.instr_cnt === exp_cnt4()) else begin
      failures++;
      $error("FAIL %s cyc=%0d instr_cnt4 got=%0d want=%0d", tag, cyc, bus4.instr_cnt, exp_cnt4());
    end
  endtask

  // Expected per-cycle trace of one instruction, derived from the
  // instruction's path through the machine and its documented controls.
  task automatic build(input kind_t k, input logic z);
    outs_t r;
    logic [1:0] e;
    exp_q.delete();
    e = (k == K_ORI) ? 2'b01 : (k == K_LUI) ? 2'b10 : (k == K_BEQ) ? 2'b11 : 2'b00;
    r = '0; r.st = 4'd0; r.pcwr = 1'b1; r.irwr = 1'b1; exp_q.push_back(r);
    r = '0; r.st = 4'd1; r.eop = e; r.ill = (k == K_ILL); exp_q.push_back(r);
    case (k)
      K_ADDU, K_SUBU, K_ORI, K_LUI: begin
        r = '0; r.st = 4'd2; r.eop = e;
        r.alusrc = (k == K_ORI || k == K_LUI);
        r.aluop  = (k == K_SUBU) ? 3'd1 : (k == K_ORI) ? 3'd2 : (k == K_LUI) ? 3'd3 : 3'd0;
        exp_q.push_back(r);
        r = '0; r.st = 4'd3; r.eop = e; r.regwr = 1'b1;
        r.regdst = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
        exp_q.push_back(r);
      end
      K_LW, K_SW: begin
        r = '0; r.st = 4'd4; r.alusrc = 1'b1; exp_q.push_back(r);
        if (k == K_LW) begin
          r = '0; r.st = 4'd5; exp_q.push_back(r);
          r = '0; r.st = 4'd6; r.regwr = 1'b1; r.m2r = 2'b01; exp_q.push_back(r);
        end else begin
          r = '0; r.st = 4'd7; r.memwr = 1'b1; exp_q.push_back(r);
        end
      end
      K_BEQ: begin
        r = '0; r.st = 4'd8; r.eop = e; r.aluop = 3'd1; r.npc = 2'b01; r.pcwr = z;
        exp_q.push_back(r);
      end
      K_J, K_JAL, K_JR: begin
        r = '0; r.st = 4'd9; r.pcwr = 1'b1; r.npc = (k == K_JR) ? 2'b11 : 2'b10;
        if (k == K_JAL) begin r.regwr = 1'b1; r.regdst = 2'b10; r.m2r = 2'b10; end
        exp_q.push_back(r);
      end
      default: ;
    endcase
  endtask

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) return (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b001000);
    return (op == 6'b001101 || op == 6'b001111 || op == 6'b100011 || op == 6'b101011 ||
            op == 6'b000100 || op == 6'b000010 || op == 6'b000011);
  endfunction

  task automatic encode(input kind_t k, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    case (k)
      K_ADDU: begin op = 6'b000000; fn = 6'b100001; end
      K_SUBU: begin op = 6'b000000; fn = 6'b100011; end
      K_JR:   begin op = 6'b000000; fn = 6'b001000; end
      K_ORI:  op = 6'b001101;
      K_LUI:  op = 6'b001111;
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_BEQ:  op = 6'b000100;
      K_J:    op = 6'b000010;
      K_JAL:  op = 6'b000011;
      default: begin
        op = 6'b111111;
        for (int t = 0; t < 50; t++) begin
          logic [5:0] a, b;
          a = ($urandom_range(0, 3) == 0) ? 6'b000000 : 6'($urandom);
          b = 6'($urandom);
          if (!is_legal(a, b)) begin op = a; fn = b; break; end
        end
      end
    endcase
  endtask

  // Entered just after a rising edge with the DUT in FETCH. Runs the first
  // ncyc cycles of the trace (all of it when ncyc < 0).
  task automatic run_raw(input kind_t k, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int ncyc);
    int n;
    bus.opcode = op;  bus4.opcode = op;
    bus.funct  = fn;  bus4.funct  = fn;
    bus.zero   = z;   bus4.zero   = z;
    build(k, z);
    n = (ncyc < 0) ? exp_q.size() : ncyc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cycle(k.name(), i, exp_q[i]);
      @(posedge clk);
      #1;
    end
    if (ncyc < 0 && k != K_ILL) model_cnt++;
  endtask

  task automatic run_instr(input kind_t k, input logic z);
    logic [5:0] op, fn;
    encode(k, op, fn);
    run_raw(k, op, fn, z, -1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_cycle(tag, 0, outs_t'(0));
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0;
    bus4.opcode = '0; bus4.funct = '0; bus4.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_cnt = 0;
    check_reset_outputs("reset_state");
    reset = 1'b0;

    // ori after reset: 0,1,2,3
    run_instr(K_ORI, 1'b0);
    // lw then sw
    run_instr(K_LW, 1'b0);
    run_instr(K_SW, 1'b1);
    // beq taken and not taken
    run_instr(K_BEQ, 1'b1);
    run_instr(K_BEQ, 1'b0);
    // jal then jr
    run_instr(K_JAL, 1'b0);
    run_instr(K_JR, 1'b1);
    // opcode 111111: two cycles, no count
    run_raw(K_ILL, 6'b111111, 6'b000000, 1'b0, -1);
    // R-type with unsupported funct
    run_raw(K_ILL, 6'b000000, 6'b100000, 1'b0, -1);
    run_instr(K_J, 1'b0);
    run_instr(K_LUI, 1'b0);
    run_instr(K_SUBU, 1'b0);

    // reset asserted while in MRD
    run_raw(K_LW, 6'b100011, 6'b000000, 1'b0, 3);
    checks++;
    assert (bus.state === 4'd5) else begin
      failures++;
      $error("FAIL pre_reset_state got=%0d want=5", bus.state);
    end
    reset = 1'b1;
    #1;
    model_cnt = 0;
    check_reset_outputs("reset_in_mrd");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 5 addu from a clean count, then 12 more legal ones (17 total)
    for (int i = 0; i < 5; i++) run_instr(K_ADDU, 1'b0);
    checks++;
    assert (bus.instr_cnt === (CNT_ON ? 32'd5 : 32'd0)) else begin
      failures++;
      $error("FAIL cnt_after_5_addu got=%0d want=%0d", bus.instr_cnt, CNT_ON ? 5 : 0);
    end
    for (int i = 0; i < 12; i++) run_instr(kind_t'($urandom_range(0, 9)), 1'($urandom));
    checks++;
    assert (bus4.instr_cnt === (CNT_ON ? 4'd1 : 4'd0)) else begin
      failures++;
      $error("FAIL cnt4_wrap_17 got=%0d want=%0d", bus4.instr_cnt, CNT_ON ? 1 : 0);
    end

    // randomized mix including illegal encodings
    for (int i = 0; i < 150; i++) run_instr(kind_t'($urandom_range(0, 10)), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port opcode, input, 6, IR[31:26], stable from DECODE until the next FETCH.
REQ-005 SHALL have port funct, input, 6, IR[5:0].
REQ-006 SHALL have port zero, input, 1, ALU equality flag.
REQ-007 SHALL have outputs PCWr, IRWr, RegWr and MemWr, each 1 bit: write enables for the PC, the IR, the register file and data memory.
REQ-008 SHALL have output EOp, 2 bits, extender mode: 00 sign, 01 zero, 10 upper (imm<<16), 11 sign<<2.
REQ-009 SHALL have output ALUSrc, 1 bit: 0 selects rt, 1 selects ext.
REQ-010 SHALL have output ALUOp, 3 bits: 000 add, 001 sub, 010 or, 011 pass-B.
REQ-011 SHALL have output RegDst, 2 bits: 00 rt, 01 rd, 10 $31.
REQ-012 SHALL have output MemtoReg, 2 bits: 00 ALU, 01 memory, 10 PC+4.
REQ-013 SHALL have output NPCOp, 2 bits: 00 PC+4, 01 branch, 10 j/jal target, 11 GPR[rs].
REQ-014 SHALL have output state, 4 bits, current state for debug.
REQ-015 SHALL have output illegal, 1 bit, asserted for one DECODE cycle when the opcode/funct is unsupported.
REQ-016 SHALL have output instr_cnt, CNT_W bits, retired-instruction count.

Function
REQ-017 SHALL support addu, subu, jr (opcode 000000; funct 100001, 100011, 001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010 and jal 000011.
REQ-018 SHALL use the states FETCH=0, DECODE=1, EXE=2, ALUWB=3, MADDR=4, MRD=5, MWB=6, MWR=7, BR=8, JMP=9.
REQ-019 SHALL follow these transitions: FETCH->DECODE. From DECODE: addu/subu/ori/lui->EXE; lw/sw->MADDR; beq->BR; j/jal/jr->JMP; illegal->FETCH. EXE->ALUWB->FETCH. MADDR->MRD for lw, MADDR->MWR for sw. MRD->MWB->FETCH. MWR, BR and JMP->FETCH.
REQ-020 SHALL give these latencies in cycles: R-type, ori, lui and sw take 4; lw takes 5; beq, j, jal and jr take 3; an illegal instruction takes 2.
REQ-021 SHALL decode outputs combinationally from state and the latched opcode/funct (Moore style); default outputs are 0 apart from any assignment listed below.
REQ-022 SHALL drive FETCH as PCWr=1, IRWr=1, NPCOp=00.
REQ-023 SHALL drive EXE and MADDR ALUSrc=1 for ori, lui, lw and sw. ALUOp SHALL be addu 000, subu 001, ori 010, lui 011, lw/sw 000.
REQ-024 SHALL drive EOp as: ori 01, lui 10, lw/sw 00, beq 11. EOp SHALL be held constant from DECODE through the instruction's last state.
REQ-025 SHALL drive ALUWB as RegWr=1 with MemtoReg=00; RegDst=01 for R-type, 00 for ori and lui.
REQ-026 SHALL drive MWB as RegWr=1, RegDst=00, MemtoReg=01. MWR SHALL drive MemWr=1.
REQ-027 SHALL drive BR as ALUOp=001, NPCOp=01, PCWr=zero.
REQ-028 SHALL drive JMP as PCWr=1, with NPCOp=10 for j/jal and 11 for jr; jal SHALL also drive RegWr=1, RegDst=10, MemtoReg=10.
REQ-029 SHALL never assert RegWr and MemWr in the same cycle.

Reset
REQ-030 SHALL, while reset is high, force state=FETCH, all write enables=0, all select outputs=0, illegal=0 and instr_cnt=0.
REQ-031 SHALL, on reset mid-instruction, abandon the instruction with no pending write, and the first FETCH SHALL occur on the first rising edge after deassertion.

Configuration
REQ-032 SHALL compile in, with macro MC_CTRL_INSTR_CNT_EN, instr_cnt, which increments by 1 on every transition into FETCH from a final state (ALUWB, MWB, MWR, BR or JMP) and wraps at 2^CNT_W-1->0. Illegal instructions SHALL NOT count.
REQ-033 SHALL, without MC_CTRL_INSTR_CNT_EN, keep the port and drive instr_cnt constant 0, with no counter register.

Structure
REQ-034 SHALL place opcode/funct constants, state encodings and the EOp, ALUOp, RegDst, MemtoReg and NPCOp encodings in package mc_ctrl_pkg.
REQ-035 SHALL use one combinational sub-module, mc_decode, which maps opcode/funct to a one-hot instruction class plus an illegal flag.

Verification
REQ-036 SHALL cover: ori (opcode 001101) after reset -> states 0,1,2,3,0; EOp=01 in states 1-3; RegWr=1 only in state 3 with RegDst=00.
REQ-037 SHALL cover: lw followed by sw -> states 0,1,4,5,6,0,1,4,7,0; MemWr=1 only in state 7; RegWr=1 with MemtoReg=01 in state 6.
REQ-038 SHALL cover: beq with zero=1 and then beq with zero=0 -> PCWr=1 in BR for the first and PCWr=0 for the second; NPCOp=01 and EOp=11 in both.
REQ-039 SHALL cover: jal followed by jr (funct 001000) -> jal drives RegWr=1, RegDst=10, MemtoReg=10 in JMP; jr drives NPCOp=11 and RegWr=0.
REQ-040 SHALL cover: opcode 111111 -> illegal=1 for one cycle in DECODE, next state FETCH, no write enable asserted, instr_cnt unchanged.
REQ-041 SHALL cover: reset asserted in MRD -> state=0 and all enables 0 immediately; with the macro on, 5 addu instructions -> instr_cnt=5, and CNT_W=4 with 17 instructions -> instr_cnt=1.
